// File: rtl/slc3_mem_arbiter.sv
// rtl/slc3_mem_arbiter.sv - SLC-3 shared SRAM port arbiter (CPU vs debug); optional SLC3_MEM_ARB_DBG_LOCK_EN adds dbg_lock
module slc3_mem_arbiter #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ready,
`ifdef SLC3_MEM_ARB_DBG_LOCK_EN
  input  logic              dbg_lock,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_drive,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              CE,
  output logic              OE,
  output logic              WE,
  output logic              UB,
  output logic              LB,
  output logic              grant_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic       op_we;
  logic       op_dbg;
  logic       rr_last_dbg;
  logic       cpu_req_eff;
  logic       any_req;
  logic       pick_dbg;

  // A locked debug port hides the CPU from arbitration; the CPU keeps waiting
`ifdef SLC3_MEM_ARB_DBG_LOCK_EN
  assign cpu_req_eff = cpu_req & ~dbg_lock;
`else
  assign cpu_req_eff = cpu_req;
`endif

  // Round robin: on a tie the port that did not win last time is chosen
  assign any_req  = cpu_req_eff | dbg_req;
  assign pick_dbg = dbg_req & (~cpu_req_eff | ~rr_last_dbg);

  assign grant_dbg = op_dbg;

  // State register; reset drops straight to IDLE so strobes release at once
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and strobe/ready decode, all taken from the state register
  always_comb begin
    state_nxt = state;
    CE        = 1'b1;
    OE        = 1'b1;
    WE        = 1'b1;
    UB        = 1'b1;
    LB        = 1'b1;
    mem_drive = 1'b0;
    cpu_ready = 1'b0;
    dbg_ready = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        CE        = 1'b0;
        UB        = 1'b0;
        LB        = 1'b0;
        OE        = op_we;
        WE        = ~op_we;
        mem_drive = op_we;
        if (cnt == 4'd0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        cpu_ready = ~op_dbg;
        dbg_ready = op_dbg;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Grant latching, access counter and read-data capture
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mem_addr    <= '0;
      mem_wdata   <= '0;
      op_we       <= 1'b0;
      op_dbg      <= 1'b1;
      rr_last_dbg <= 1'b1;
      cnt         <= 4'd0;
      cpu_rdata   <= '0;
      dbg_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            op_dbg    <= pick_dbg;
            op_we     <= pick_dbg ? dbg_we : cpu_we;
            mem_addr  <= pick_dbg ? dbg_addr : cpu_addr;
            mem_wdata <= pick_dbg ? dbg_wdata : cpu_wdata;
            cnt       <= 4'(WAIT_CYCLES - 1);
`ifdef SLC3_MEM_ARB_DBG_LOCK_EN
            if (!dbg_lock) begin
              rr_last_dbg <= pick_dbg;
            end
`else
            rr_last_dbg <= pick_dbg;
`endif
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (!op_we) begin
            if (op_dbg) begin
              dbg_rdata <= mem_rdata;
            end else begin
              cpu_rdata <= mem_rdata;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slc3_mem_arbiter.sv
// tb/tb_slc3_mem_arbiter.sv - scoreboard bench for slc3_mem_arbiter
module tb_slc3_mem_arbiter;
  localparam int AW = 20;
  localparam int DW = 16;
  localparam int WC = 2;

  typedef struct {
    logic          dbg;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          cpu_req, cpu_we, dbg_req, dbg_we;
  logic [AW-1:0] cpu_addr, dbg_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic          cpu_ready, dbg_ready, mem_drive, grant_dbg;
  logic          CE, OE, WE, UB, LB;
`ifdef SLC3_MEM_ARB_DBG_LOCK_EN
  logic          dbg_lock;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  txn_t          exp_q[$];
  logic [DW-1:0] shadow [0:255];
  logic [DW-1:0] tb_mem [0:255] = '{default: '0};
  logic [DW-1:0] exp_cpu_rd = '0;
  logic [DW-1:0] exp_dbg_rd = '0;
  int            run = 0;
  logic          prev_ready = 1'b0;

  slc3_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC)) dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ready(dbg_ready),
`ifdef SLC3_MEM_ARB_DBG_LOCK_EN
    .dbg_lock(dbg_lock),
`endif
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_drive(mem_drive), .mem_rdata(mem_rdata),
    .CE(CE), .OE(OE), .WE(WE), .UB(UB), .LB(LB), .grant_dbg(grant_dbg)
  );

  always #5 Clk = ~Clk;

  // SRAM model
  assign mem_rdata = tb_mem[mem_addr[7:0]];
  always @(posedge Clk) begin
    if (!CE && !WE) tb_mem[mem_addr[7:0]] <= mem_wdata;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic sb_push(input logic dbg, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    txn_t t;
    t.dbg  = dbg;
    t.we   = we;
    t.addr = a;
    t.data = we ? d : shadow[a[7:0]];
    if (we) shadow[a[7:0]] = d;
    exp_q.push_back(t);
  endtask

  task automatic drive(input logic dbg, input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (dbg) begin
      dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    end else begin
      cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    end
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_strobes"}, 32'({CE, OE, WE, UB, LB}), 32'h1f);
    check_eq({tag, "_drive"}, 32'(mem_drive), 32'h0);
    check_eq({tag, "_ready"}, 32'({cpu_ready, dbg_ready}), 32'h0);
  endtask

  // Cycle-exact transaction, inputs scrambled and req dropped during ACCESS
  task automatic directed(input logic dbg, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    sb_push(dbg, we, a, d);
    drive(dbg, 1'b1, we, a, d);
    for (int i = 0; i < WC; i++) begin
      @(posedge Clk); #1;
      if (i == 0) drive(dbg, 1'b0, ~we, ~a, ~d);
      check_eq("acc_ce", 32'(CE), 32'h0);
      check_eq("acc_oe", 32'(OE), 32'(we));
      check_eq("acc_we", 32'(WE), 32'(!we));
      check_eq("acc_drive", 32'(mem_drive), 32'(we));
      check_eq("acc_addr", 32'(mem_addr), 32'(a));
      if (we) check_eq("acc_wdata", 32'(mem_wdata), 32'(d));
      check_eq("acc_ready", 32'({cpu_ready, dbg_ready}), 32'h0);
    end
    @(posedge Clk); #1;
    check_eq("done_ready", 32'({cpu_ready, dbg_ready}), dbg ? 32'h1 : 32'h2);
    check_eq("done_ce", 32'(CE), 32'h1);
    @(posedge Clk); #1;
    check_quiet("idle_after");
  endtask

  // Hold request until this port's ready, then release it
  task automatic port_txn(input logic dbg, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    logic rdy;
    drive(dbg, 1'b1, we, a, d);
    n = 0;
    do begin
      @(posedge Clk); #1;
      n++;
      rdy = dbg ? dbg_ready : cpu_ready;
    end while (!rdy && n < 60);
    check_eq(dbg ? "dbg_wait" : "cpu_wait", 32'(rdy), 32'h1);
    drive(dbg, 1'b0, we, a, d);
    @(posedge Clk); #1;
  endtask

  // Scoreboard and protocol monitor
  always @(negedge Clk) begin
    txn_t t;
    if (Reset) begin
      run        = 0;
      prev_ready = 1'b0;
      exp_cpu_rd = '0;
      exp_dbg_rd = '0;
    end else begin
      check_eq("ready_excl", 32'(cpu_ready & dbg_ready), 32'h0);
      if (!CE) begin
        run++;
        check_eq("ub_lb", 32'({UB, LB}), 32'h0);
        check_eq("oe_xor_we", 32'(OE ^ WE), 32'h1);
        check_eq("drive_vs_we", 32'(mem_drive), 32'(!WE));
      end else begin
        check_eq("idle_strobes", 32'({OE, WE, UB, LB, mem_drive}), 32'h1e);
        if (run > 0) begin
          check_eq("access_len", 32'(run), 32'(WC));
          run = 0;
        end
      end
      if (prev_ready) check_eq("idle_gap", 32'(CE), 32'h1);
      if (cpu_ready || dbg_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_ready", 32'h1, 32'h0);
        end else begin
          t = exp_q.pop_front();
          check_eq("port", 32'(dbg_ready), 32'(t.dbg));
          check_eq("grant_dbg", 32'(grant_dbg), 32'(t.dbg));
          if (!t.we) begin
            if (t.dbg) exp_dbg_rd = t.data;
            else       exp_cpu_rd = t.data;
          end else begin
            check_eq("mem_write", 32'(tb_mem[t.addr[7:0]]), 32'(t.data));
          end
        end
        check_eq("cpu_rdata", 32'(cpu_rdata), 32'(exp_cpu_rd));
        check_eq("dbg_rdata", 32'(dbg_rdata), 32'(exp_dbg_rd));
      end
      prev_ready = cpu_ready | dbg_ready;
    end
  end

  initial begin
    Reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
`ifdef SLC3_MEM_ARB_DBG_LOCK_EN
    dbg_lock = 1'b0;
`endif
    for (int i = 0; i < 256; i++) shadow[i] = '0;

    repeat (3) @(posedge Clk);
    #1;
    check_quiet("in_reset");
    check_eq("rst_grant_dbg", 32'(grant_dbg), 32'h1);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'h0);
    check_eq("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    Reset = 1'b0;
    @(posedge Clk); #1;
    check_quiet("after_reset");
    check_eq("rst_rdata", 32'({cpu_rdata, dbg_rdata}), 32'h0);

    // Loader writes, CPU reads back, debug write
    directed(1'b1, 1'b1, 20'h00012, 16'h1234);
    directed(1'b0, 1'b0, 20'h00012, 16'h0000);
    directed(1'b1, 1'b1, 20'h00030, 16'hBEEF);

    // Both requesting continuously: CPU, DBG, CPU, DBG
    sb_push(1'b0, 1'b0, 20'h00030, 16'h0);
    sb_push(1'b1, 1'b0, 20'h00012, 16'h0);
    sb_push(1'b0, 1'b1, 20'h00050, 16'h5555);
    sb_push(1'b1, 1'b0, 20'h00050, 16'h0);
    fork
      begin
        port_txn(1'b0, 1'b0, 20'h00030, 16'h0);
        port_txn(1'b0, 1'b1, 20'h00050, 16'h5555);
      end
      begin
        port_txn(1'b1, 1'b0, 20'h00012, 16'h0);
        port_txn(1'b1, 1'b0, 20'h00050, 16'h0);
      end
    join

    // Random single-port traffic
    for (int k = 0; k < 8; k++) begin
      logic          p, w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      p = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      a = AW'($urandom_range(8'h80, 8'hff));
      d = DW'($urandom);
      sb_push(p, w, a, d);
      port_txn(p, w, a, d);
    end

    // Reset during the second ACCESS cycle of a write
    drive(1'b1, 1'b1, 1'b1, 20'h00040, 16'hDEAD);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    check_eq("pre_rst_ce_we", 32'({CE, WE}), 32'h0);
    #2 Reset = 1'b1;
    #1;
    check_eq("rst_ce_we", 32'({CE, WE}), 32'h3);
    check_eq("rst_drive", 32'(mem_drive), 32'h0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    @(posedge Clk); #1;
    check_eq("rst_no_ready", 32'({cpu_ready, dbg_ready}), 32'h0);
    Reset = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check_quiet("post_rst");
    check_eq("post_rst_grant", 32'(grant_dbg), 32'h1);
    check_eq("post_rst_rdata", 32'({cpu_rdata, dbg_rdata}), 32'h0);
    directed(1'b0, 1'b0, 20'h00012, 16'h0000);

`ifdef SLC3_MEM_ARB_DBG_LOCK_EN
    // Locked: debug only; unlocking lets the waiting CPU in
    dbg_lock = 1'b1;
    sb_push(1'b1, 1'b1, 20'h00060, 16'h0A0A);
    sb_push(1'b1, 1'b0, 20'h00060, 16'h0);
    sb_push(1'b0, 1'b0, 20'h00030, 16'h0);
    fork
      port_txn(1'b0, 1'b0, 20'h00030, 16'h0);
      begin
        port_txn(1'b1, 1'b1, 20'h00060, 16'h0A0A);
        port_txn(1'b1, 1'b0, 20'h00060, 16'h0);
        dbg_lock = 1'b0;
      end
    join
`endif

    repeat (3) @(posedge Clk);
    #1;
    check_eq("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
